// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive and transmit datapaths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_MAC_DEST,
        ST_MAC_SRC,
        ST_ETHER_TYPE,
        ST_PAYLOAD,
        ST_DROP
    } eth_rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // Per-frame error flags reported alongside frame_done.
    typedef struct packed {
        logic crc;
        logic runt;
        logic long;
        logic phy;
    } eth_rx_status_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Reflected CRC-32 advance by one byte (LSB of the byte enters first).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module eth_crc32_byte (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    import eth_pkg::*;

    logic [31:0] c;

    // Eight bit-serial shift/XOR steps unrolled into one byte step.
    always_comb begin
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
    end

    assign crc_out = c;

endmodule

// File: rtl/eth_rx_parser.sv
// GMII receive parser: strips preamble/SFD, captures header, streams payload, checks FCS.
// Latency: payload byte appears 5 bytes after it is received (FCS holdback); status 1 cycle after rx_dv falls.
// Backpressure: none; the PHY cannot stall. Optional ETH_RX_ADDR_FILTER_EN adds my_mac destination filtering.
module eth_rx_parser #(
    parameter int MIN_FRAME    = 64,
    parameter int MAX_FRAME    = 1518,
    parameter int PREAMBLE_MIN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_data,
`ifdef ETH_RX_ADDR_FILTER_EN
    input  logic [47:0] my_mac,
`endif
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        hdr_valid,
    output logic [47:0] hdr_dest,
    output logic [47:0] hdr_src,
    output logic [15:0] hdr_type,
    output logic        frame_done,
    output logic        frame_good,
    output logic        err_crc,
    output logic        err_runt,
    output logic        err_long,
    output logic        err_phy,
    output logic [10:0] frame_len
);
    import eth_pkg::*;

    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
    localparam logic [10:0] LEN_SAT = 11'(MAX_FRAME + 1);
    localparam logic [2:0]  PRE_MIN = 3'(PREAMBLE_MIN);

    eth_rx_state_t  state_q;
    logic           prev_dv;
    logic [2:0]     pre_cnt;
    logic [2:0]     byte_cnt;
    logic [47:0]    dest_sr;
    logic [47:0]    src_sr;
    logic [7:0]     type_hi;
    logic [4:0][7:0] dl;        // [0] newest ... [4] oldest
    logic [2:0]     dl_cnt;
    logic [31:0]    crc_q;
    logic [31:0]    crc_next;
    logic [10:0]    len_q;
    logic [10:0]    len_inc;
    logic           acc_phy;
    logic           acc_long;
    logic           drop_report;  // DROP entered from a parsed frame that still owes a status
    logic           dest_ok;
    eth_rx_status_t end_stat;
    eth_rx_status_t stat_q;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (rx_data),
        .crc_out (crc_next)
    );

    assign len_inc = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;

`ifdef ETH_RX_ADDR_FILTER_EN
    logic [47:0] dest_full;
    assign dest_full = {dest_sr[39:0], rx_data};
    assign dest_ok   = (dest_full == my_mac) || (dest_full == BROADCAST_MAC);
`else
    assign dest_ok   = 1'b1;
`endif

    // Status a frame ending in the current state would report.
    always_comb begin
        end_stat      = '0;
        end_stat.phy  = acc_phy;
        end_stat.long = acc_long;
        end_stat.crc  = (state_q == ST_PAYLOAD) && (crc_q != CRC_RESIDUE);
        end_stat.runt = (state_q != ST_DROP) &&
                        ((state_q != ST_PAYLOAD) || (dl_cnt != 3'd5) || (len_q < MIN_LEN));
    end

    assign err_crc  = stat_q.crc;
    assign err_runt = stat_q.runt;
    assign err_long = stat_q.long;
    assign err_phy  = stat_q.phy;

    // Frame parser FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prev_dv     <= 1'b1;
            pre_cnt     <= '0;
            byte_cnt    <= '0;
            dest_sr     <= '0;
            src_sr      <= '0;
            type_hi     <= '0;
            dl          <= '0;
            dl_cnt      <= '0;
            crc_q       <= CRC_INIT;
            len_q       <= '0;
            acc_phy     <= 1'b0;
            acc_long    <= 1'b0;
            drop_report <= 1'b0;
            stat_q      <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            hdr_valid   <= 1'b0;
            hdr_dest    <= '0;
            hdr_src     <= '0;
            hdr_type    <= '0;
            frame_done  <= 1'b0;
            frame_good  <= 1'b0;
            frame_len   <= '0;
        end else begin
            prev_dv    <= rx_dv;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            hdr_valid  <= 1'b0;
            frame_done <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rx_dv && !prev_dv) begin
                        drop_report <= 1'b0;
                        if (rx_data == PREAMBLE_BYTE) begin
                            state_q  <= ST_PREAMBLE;
                            pre_cnt  <= 3'd1;
                            byte_cnt <= '0;
                            dl_cnt   <= '0;
                            crc_q    <= CRC_INIT;
                            len_q    <= '0;
                            acc_phy  <= rx_er;
                            acc_long <= 1'b0;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                end

                ST_PREAMBLE: begin
                    if (!rx_dv) begin
                        state_q <= ST_DROP;
                    end else begin
                        acc_phy <= acc_phy | rx_er;
                        if (rx_data == PREAMBLE_BYTE) begin
                            pre_cnt <= (pre_cnt == 3'd7) ? pre_cnt : pre_cnt + 3'd1;
                        end else if (rx_data == SFD_BYTE && pre_cnt >= PRE_MIN) begin
                            state_q <= ST_MAC_DEST;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                end

                ST_MAC_DEST, ST_MAC_SRC, ST_ETHER_TYPE, ST_PAYLOAD: begin
                    if (!rx_dv) begin
                        // Normal or truncated end: flush last payload byte if the FCS window is full.
                        if (state_q == ST_PAYLOAD && dl_cnt == 3'd5) begin
                            m_valid <= 1'b1;
                            m_last  <= 1'b1;
                            m_data  <= dl[4];
                        end
                        frame_done <= 1'b1;
                        frame_len  <= len_q;
                        stat_q     <= end_stat;
                        frame_good <= ~|end_stat;
                        state_q    <= ST_IDLE;
                    end else begin
                        crc_q   <= crc_next;
                        len_q   <= len_inc;
                        acc_phy <= acc_phy | rx_er;
                        case (state_q)
                            ST_MAC_DEST: begin
                                dest_sr <= {dest_sr[39:0], rx_data};
                                if (byte_cnt == 3'd5) begin
                                    byte_cnt <= '0;
                                    state_q  <= dest_ok ? ST_MAC_SRC : ST_DROP;
                                end else begin
                                    byte_cnt <= byte_cnt + 3'd1;
                                end
                            end
                            ST_MAC_SRC: begin
                                src_sr <= {src_sr[39:0], rx_data};
                                if (byte_cnt == 3'd5) begin
                                    byte_cnt <= '0;
                                    state_q  <= ST_ETHER_TYPE;
                                end else begin
                                    byte_cnt <= byte_cnt + 3'd1;
                                end
                            end
                            ST_ETHER_TYPE: begin
                                if (byte_cnt == 3'd0) begin
                                    type_hi  <= rx_data;
                                    byte_cnt <= 3'd1;
                                end else begin
                                    byte_cnt  <= '0;
                                    hdr_valid <= 1'b1;
                                    hdr_dest  <= dest_sr;
                                    hdr_src   <= src_sr;
                                    hdr_type  <= {type_hi, rx_data};
                                    state_q   <= ST_PAYLOAD;
                                end
                            end
                            ST_PAYLOAD: begin
                                dl <= {dl[3:0], rx_data};
                                if (len_inc == LEN_SAT) begin
                                    // Oversize: cut the stream here, status follows when rx_dv drops.
                                    acc_long    <= 1'b1;
                                    drop_report <= 1'b1;
                                    state_q     <= ST_DROP;
                                end else if (dl_cnt == 3'd5) begin
                                    m_valid <= 1'b1;
                                    m_data  <= dl[4];
                                end else begin
                                    dl_cnt <= dl_cnt + 3'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_DROP: begin
                    if (!rx_dv) begin
                        state_q <= ST_IDLE;
                        if (drop_report) begin
                            frame_done <= 1'b1;
                            frame_len  <= len_q;
                            stat_q     <= end_stat;
                            frame_good <= ~|end_stat;
                        end
                    end else if (drop_report) begin
                        acc_phy <= acc_phy | rx_er;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/eth_rx_parser.md
Name: eth_rx_parser

Overview:
- Receive-side counterpart of the Ethernet transmit path; consumes the GMII-style byte stream from the PHY.
- Strips preamble/SFD and captures destination MAC, source MAC and EtherType.
- Streams payload bytes out, discarding the FCS, and checks CRC-32.
- Reports per-frame status to the MAC-layer consumer. No backpressure: the PHY cannot stall.

Parameters:
- MIN_FRAME, 64: minimum legal frame length in bytes, dest MAC through FCS inclusive.
- MAX_FRAME, 1518: maximum legal frame length in bytes, dest MAC through FCS inclusive.
- PREAMBLE_MIN, 1: minimum count of 0x55 bytes accepted before the SFD.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- rx_dv  in  1  PHY data valid; high for the whole frame
- rx_er  in  1  PHY receive error
- rx_data  in  8  received byte
- m_valid  out  1  payload byte valid (single-cycle qualifier)
- m_data  out  8  payload byte
- m_last  out  1  final payload byte of a normally terminated frame
- hdr_valid  out  1  one-cycle pulse; header fields are stable from this pulse until the next frame's hdr_valid
- hdr_dest  out  48  destination MAC; first wire byte is [47:40]
- hdr_src  out  48  source MAC; same byte order
- hdr_type  out  16  EtherType, big-endian
- frame_done  out  1  one-cycle end-of-frame pulse; the authoritative frame boundary
- frame_good  out  1  valid with frame_done; no error flag set
- err_crc, err_runt, err_long, err_phy  out  1 each  valid with frame_done
- frame_len  out  11  bytes from dest MAC through FCS; valid with frame_done, saturates at MAX_FRAME+1

Behaviour:
- One clock (clock). Reset (reset) is synchronous and active-high.
- Reset values:
  - all outputs 0; state IDLE; CRC register 0xFFFFFFFF
  - prev_dv treated as 1, so a frame already in progress at reset release is ignored until rx_dv falls.
- Inputs are sampled every cycle; all outputs are registered.
- States: IDLE, PREAMBLE, MAC_DEST, MAC_SRC, ETHER_TYPE, PAYLOAD, DROP.
- IDLE: on rx_dv rising edge (rx_dv=1, prev_dv=0) with rx_data=0x55 -> PREAMBLE; a rising edge with any other byte -> DROP.
- PREAMBLE:
  - 0x55 increments the preamble count, saturating at 7.
  - 0xD5 with count >= PREAMBLE_MIN -> MAC_DEST.
  - Any other byte, or rx_dv low -> DROP.
- MAC_DEST: 6 bytes, then MAC_SRC: 6 bytes, then ETHER_TYPE: 2 bytes.
  - hdr_valid pulses the cycle after the second EtherType byte is sampled; then PAYLOAD.
- PAYLOAD: each byte enters a 5-byte delay line.
  - When the line is full, each new byte pushes out the oldest as m_valid=1 on the next cycle.
  - The 4 newest bytes are always FCS candidates.
- CRC:
  - reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF
  - covers every byte from the first dest MAC byte through the last FCS byte
  - pass iff the final register = 0xDEBB20E3 (residue)
- frame_len counts every byte from MAC_DEST onward.
- End of frame (rx_dv sampled 0 in any state except IDLE/DROP):
  - If the delay line is full, emit its oldest byte with m_last=1. frame_done asserts on that same cycle.
  - If the delay line is not full, emit no data; err_runt=1.
- Errors:
  - err_runt=1 if frame_len < MIN_FRAME, or if the frame ends before PAYLOAD.
  - err_long: when frame_len reaches MAX_FRAME+1, stop m_valid immediately, enter DROP, set err_long; m_last is not emitted.
  - err_phy: rx_er=1 on any byte of a frame sets err_phy; parsing continues.
  - err_crc: set on a CRC mismatch, evaluated only when a frame reaches PAYLOAD.
  - frame_good = ~|errors.
- DROP: wait until rx_dv=0.
  - frame_done pulses one cycle after rx_dv falls, except for frames rejected in IDLE/PREAMBLE, which produce no status.
- Back-to-back frames: a rising edge on the cycle after the falling edge is accepted. All counters, CRC and error flags clear on entry to PREAMBLE.

Optional Feature:
- Macro: ETH_RX_ADDR_FILTER_EN.
- With the macro defined:
  - adds input port my_mac (48).
  - after the 6th dest byte, frames whose dest is neither my_mac nor FF:FF:FF:FF:FF:FF go to DROP.
  - dropped frames produce no hdr_valid, no m_valid and no frame_done.
- Without the macro: promiscuous; all frames are parsed and the port is absent.

Decomposition:
- Package eth_pkg holds:
  - state enum
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_POLY, CRC_INIT, CRC_RESIDUE, BROADCAST_MAC
  - status struct {crc, runt, long, phy}
- Sub-module eth_crc32_byte: combinational next-CRC from (crc, byte). It is shared with the transmitter's FCS generator.

Test Plan:
- Good frame, 7x55/D5, dest 02:00:00:00:00:01, src 02:00:00:00:00:02, type 0x0800, 46 bytes 0x00..0x2D, correct FCS -> hdr_valid with those fields; 46 m_valid, last 0x2D with m_last; frame_done, frame_good=1, frame_len=64.
- Same frame with payload byte 10 flipped -> 46 bytes streamed, err_crc=1, frame_good=0.
- 40-byte frame with correct FCS -> err_runt=1, frame_len=40.
- 1600-byte frame -> m_valid stops after frame_len=1519; err_long=1 at frame_done; no m_last.
- Preamble 55 55 12 ... -> no hdr_valid, no frame_done. rx_er pulse mid-payload -> err_phy=1. Reset asserted mid-payload then released with rx_dv still high -> no outputs until the next rising edge.
- With ETH_RX_ADDR_FILTER_EN, my_mac=02:00:00:00:00:01: dest ..:03 -> silent drop; dest FF:FF:FF:FF:FF:FF -> accepted.
